// File: rtl/frame_capture_mem.sv
// -----------------------------------------------------------------------------
// frame_capture_mem
//
// Captures one frame of DEPTH 8-bit pixels into an on-chip memory and keeps a
// running pixel count and an unsigned checksum of the captured pixels. A
// registered read port gives access to the stored frame in every state.
//
// Control flow:
//   IDLE    -- waits for i_arm; pixels are ignored.
//   CAPTURE -- every i_in_valid cycle stores one pixel at address o_count.
//              Gaps in i_in_valid are allowed and simply hold state.
//   DONE    -- frame complete; further pixels are dropped and raise the
//              sticky o_overflow flag. i_arm starts a new frame. The memory
//              is not cleared, so the previous frame stays readable.
//
// Ports:
//   clk          rising-edge clock for all state
//   rst          synchronous, active-low reset
//   i_arm        one-cycle request to start a capture (IDLE or DONE only)
//   i_in_valid   pixel present on i_in_data this cycle
//   i_in_data    pixel value
//   i_rd_en      read request
//   i_rd_addr    read address; addresses >= DEPTH read back as zero
//   o_rd_data    registered read data (holds while i_rd_en is low)
//   o_rd_valid   o_rd_data valid, one cycle after i_rd_en
//   o_busy       high while capturing
//   o_done       high while the frame is complete
//   o_count      pixels captured in the current frame
//   o_checksum   unsigned sum of the captured pixels (cannot wrap)
//   o_overflow   sticky: pixel offered while DONE
// -----------------------------------------------------------------------------
module frame_capture_mem #(
   parameter int unsigned DEPTH  = 784,
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_arm,
   input  logic              i_in_valid,
   input  logic [7:0]        i_in_data,
   input  logic              i_rd_en,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [7:0]        o_rd_data,
   output logic              o_rd_valid,
   output logic              o_busy,
   output logic              o_done,
   output logic [ADDR_W-1:0] o_count,
   output logic [17:0]       o_checksum,
   output logic              o_overflow
);

   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StCapture = 2'd1,
      StDone    = 2'd2
   } state_e;

   state_e            r_state;
   state_e            w_state_d;
   logic [ADDR_W-1:0] r_count;
   logic [ADDR_W-1:0] w_count_d;
   logic [17:0]       r_checksum;
   logic [17:0]       w_checksum_d;
   logic              r_overflow;
   logic              w_overflow_d;
   logic              w_mem_we;

   logic [7:0]        r_mem [DEPTH];
   logic [7:0]        r_rd_data;
   logic              r_rd_valid;
   logic              w_rd_in_range;

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      w_state_d    = r_state;
      w_count_d    = r_count;
      w_checksum_d = r_checksum;
      w_overflow_d = r_overflow;
      w_mem_we     = 1'b0;

      case (r_state)
         StIdle: begin
            // A pixel arriving together with i_arm is not part of the frame.
            if (i_arm) begin
               w_state_d    = StCapture;
               w_count_d    = '0;
               w_checksum_d = '0;
               w_overflow_d = 1'b0;
            end
         end

         StCapture: begin
            if (i_in_valid) begin
               w_mem_we     = 1'b1;
               w_count_d    = r_count + 1'b1;
               w_checksum_d = r_checksum + 18'(i_in_data);
               if (r_count == LastAddr) begin
                  w_state_d = StDone;
               end
            end
         end

         StDone: begin
            // Re-arm wins over a same-cycle pixel: that pixel is dropped
            // without flagging overflow.
            if (i_arm) begin
               w_state_d    = StCapture;
               w_count_d    = '0;
               w_checksum_d = '0;
               w_overflow_d = 1'b0;
            end else if (i_in_valid) begin
               w_overflow_d = 1'b1;
            end
         end

         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Control state
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= StIdle;
         r_count    <= '0;
         r_checksum <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_count    <= w_count_d;
         r_checksum <= w_checksum_d;
         r_overflow <= w_overflow_d;
      end
   end

   // --------------------------------------------------------------------------
   // Pixel memory (not reset). Write is suppressed during reset so a reset
   // mid-frame cannot sneak one more pixel in.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst && w_mem_we) begin
         r_mem[r_count] <= i_in_data;
      end
   end

   // --------------------------------------------------------------------------
   // Read port. Non-blocking update of r_mem in the write block gives
   // read-first behaviour when read and write hit the same address.
   // --------------------------------------------------------------------------
   assign w_rd_in_range = (32'(i_rd_addr) < DEPTH);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else if (i_rd_en) begin
         r_rd_valid <= 1'b1;
         r_rd_data  <= w_rd_in_range ? r_mem[i_rd_addr] : 8'h00;
      end else begin
         r_rd_valid <= 1'b0;
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign o_busy     = (r_state == StCapture);
   assign o_done     = (r_state == StDone);
   assign o_count    = r_count;
   assign o_checksum = r_checksum;
   assign o_overflow = r_overflow;
   assign o_rd_data  = r_rd_data;
   assign o_rd_valid = r_rd_valid;

endmodule

// File: tb/tb_frame_capture_mem.sv
// -----------------------------------------------------------------------------
// tb_frame_capture_mem
//
// Directed scenarios followed by a randomized phase. A frame-level reference
// model (mode, pixel list, sums) runs alongside the DUT and a compare process
// checks every output on each falling edge. Directed scenarios also pin key
// results against hand-computed constants.
// -----------------------------------------------------------------------------
module tb_frame_capture_mem;

   localparam int DEPTH  = 784;
   localparam int ADDR_W = 10;

   logic              clk;
   logic              rst;
   logic              i_arm;
   logic              i_in_valid;
   logic [7:0]        i_in_data;
   logic              i_rd_en;
   logic [ADDR_W-1:0] i_rd_addr;
   logic [7:0]        o_rd_data;
   logic              o_rd_valid;
   logic              o_busy;
   logic              o_done;
   logic [ADDR_W-1:0] o_count;
   logic [17:0]       o_checksum;
   logic              o_overflow;

   int checks = 0;
   int errors = 0;

   frame_capture_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .i_arm      (i_arm),
      .i_in_valid (i_in_valid),
      .i_in_data  (i_in_data),
      .i_rd_en    (i_rd_en),
      .i_rd_addr  (i_rd_addr),
      .o_rd_data  (o_rd_data),
      .o_rd_valid (o_rd_valid),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_count    (o_count),
      .o_checksum (o_checksum),
      .o_overflow (o_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: mode 0 = waiting for arm, 1 = collecting, 2 = full frame
   // ---------------------------------------------------------------------------
   int         m_mode;
   int         m_count;
   int         m_sum;
   bit         m_ovf;
   bit         m_rv;
   logic [7:0] m_rd;
   bit         m_rd_known;
   logic [7:0] m_mem [DEPTH];
   bit         m_wr  [DEPTH];
   bit         m_init = 1'b0;

   always @(posedge clk) begin
      if (!rst) begin
         m_init     = 1'b1;
         m_mode     = 0;
         m_count    = 0;
         m_sum      = 0;
         m_ovf      = 1'b0;
         m_rv       = 1'b0;
         m_rd       = 8'h00;
         m_rd_known = 1'b1;
      end else if (m_init) begin
         // Read sees the memory as it was before this edge's write.
         if (i_rd_en) begin
            m_rv = 1'b1;
            if (int'(i_rd_addr) >= DEPTH) begin
               m_rd       = 8'h00;
               m_rd_known = 1'b1;
            end else begin
               m_rd       = m_mem[i_rd_addr];
               m_rd_known = m_wr[i_rd_addr];
            end
         end else begin
            m_rv = 1'b0;
         end
         if (m_mode == 1) begin
            if (i_in_valid) begin
               m_mem[m_count] = i_in_data;
               m_wr[m_count]  = 1'b1;
               m_count++;
               m_sum += int'(i_in_data);
               if (m_count == DEPTH) m_mode = 2;
            end
         end else if (i_arm) begin
            m_mode  = 1;
            m_count = 0;
            m_sum   = 0;
            m_ovf   = 1'b0;
         end else if (m_mode == 2 && i_in_valid) begin
            m_ovf = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         check("busy",     32'(o_busy),     32'(m_mode == 1));
         check("done",     32'(o_done),     32'(m_mode == 2));
         check("count",    32'(o_count),    32'(m_count));
         check("checksum", 32'(o_checksum), 32'(m_sum));
         check("overflow", 32'(o_overflow), 32'(m_ovf));
         check("rd_valid", 32'(o_rd_valid), 32'(m_rv));
         if (m_rd_known) check("rd_data", 32'(o_rd_data), 32'(m_rd));
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers (inputs change 1 time unit after the rising edge)
   // ---------------------------------------------------------------------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input int n, input logic [7:0] val);
      for (int i = 0; i < n; i++) begin
         i_in_valid = 1'b1;
         i_in_data  = val;
         cyc();
      end
      i_in_valid = 1'b0;
   endtask

   task automatic arm_now();
      i_arm = 1'b1;
      cyc();
      i_arm = 1'b0;
   endtask

   task automatic rd_check(input int addr, input logic [7:0] exp, input string name);
      i_rd_en   = 1'b1;
      i_rd_addr = ADDR_W'(addr);
      cyc();
      i_rd_en = 1'b0;
      check({name, "_valid"}, 32'(o_rd_valid), 32'd1);
      check(name, 32'(o_rd_data), 32'(exp));
   endtask

   // sum of (i mod 256) for i = 0..783: 3 * 32640 + (0+..+15)
   localparam int RampSum = 98040;

   initial begin
      rst        = 1'b0;
      i_arm      = 1'b0;
      i_in_valid = 1'b0;
      i_in_data  = 8'h00;
      i_rd_en    = 1'b0;
      i_rd_addr  = '0;
      repeat (3) cyc();
      check("rst_count",    32'(o_count),    32'd0);
      check("rst_checksum", 32'(o_checksum), 32'd0);
      check("rst_busy",     32'(o_busy),     32'd0);
      check("rst_done",     32'(o_done),     32'd0);
      check("rst_overflow", 32'(o_overflow), 32'd0);
      check("rst_rd_valid", 32'(o_rd_valid), 32'd0);
      check("rst_rd_data",  32'(o_rd_data),  32'd0);
      rst = 1'b1;

      // Pixels in IDLE are ignored.
      feed(5, 8'h33);
      check("idle_count", 32'(o_count), 32'd0);
      check("idle_busy",  32'(o_busy),  32'd0);

      // Arm with a same-cycle pixel, then a contiguous ramp frame.
      i_arm      = 1'b1;
      i_in_valid = 1'b1;
      i_in_data  = 8'hEE;
      cyc();
      i_arm = 1'b0;
      check("arm_busy",  32'(o_busy),  32'd1);
      check("arm_count", 32'(o_count), 32'd0);
      for (int i = 0; i < DEPTH; i++) begin
         i_in_valid = 1'b1;
         i_in_data  = 8'(i);
         cyc();
         if (i == DEPTH - 2) check("ramp_not_done", 32'(o_done), 32'd0);
      end
      i_in_valid = 1'b0;
      check("ramp_done",     32'(o_done),     32'd1);
      check("ramp_busy",     32'(o_busy),     32'd0);
      check("ramp_count",    32'(o_count),    32'd784);
      check("ramp_checksum", 32'(o_checksum), 32'(RampSum));
      check("ramp_overflow", 32'(o_overflow), 32'd0);

      rd_check(0,   8'h00, "rd0");
      rd_check(5,   8'h05, "rd5");
      rd_check(783, 8'h0F, "rd783");
      rd_check(800, 8'h00, "rd800");
      cyc();
      check("rd_idle_valid", 32'(o_rd_valid), 32'd0);
      check("rd_hold_data",  32'(o_rd_data),  32'd0);

      // Overflow while DONE, then re-arm clears it (same-cycle pixel dropped).
      feed(1, 8'hFF);
      check("ovf_flag",     32'(o_overflow), 32'd1);
      check("ovf_checksum", 32'(o_checksum), 32'(RampSum));
      check("ovf_count",    32'(o_count),    32'd784);
      i_arm      = 1'b1;
      i_in_valid = 1'b1;
      i_in_data  = 8'h77;
      cyc();
      i_arm      = 1'b0;
      i_in_valid = 1'b0;
      check("rearm_overflow", 32'(o_overflow), 32'd0);
      check("rearm_count",    32'(o_count),    32'd0);
      check("rearm_busy",     32'(o_busy),     32'd1);

      // Same ramp with in_valid toggling: 1567 stream cycles.
      for (int c = 0; c < 2 * DEPTH - 1; c++) begin
         i_in_valid = ((c % 2) == 0);
         i_in_data  = 8'(c / 2);
         cyc();
         if (c == 2 * DEPTH - 3) check("gap_not_done", 32'(o_done), 32'd0);
      end
      i_in_valid = 1'b0;
      check("gap_done",     32'(o_done),     32'd1);
      check("gap_checksum", 32'(o_checksum), 32'(RampSum));
      rd_check(783, 8'h0F, "gap_rd783");
      rd_check(300, 8'h2C, "gap_rd300");

      // Reset mid-frame abandons it; arm required to restart.
      arm_now();
      for (int i = 0; i < 300; i++) begin
         i_in_valid = 1'b1;
         i_in_data  = 8'($urandom);
         cyc();
      end
      i_in_valid = 1'b0;
      i_arm      = 1'b1;
      rst        = 1'b0;
      cyc();
      rst   = 1'b1;
      i_arm = 1'b0;
      check("mid_rst_count", 32'(o_count), 32'd0);
      check("mid_rst_busy",  32'(o_busy),  32'd0);
      check("mid_rst_done",  32'(o_done),  32'd0);
      feed(4, 8'h9C);
      check("post_rst_count", 32'(o_count), 32'd0);
      arm_now();
      feed(DEPTH, 8'h01);
      check("ones_checksum", 32'(o_checksum), 32'd784);
      check("ones_done",     32'(o_done),     32'd1);

      // Read-first on a same-address read/write.
      arm_now();
      feed(DEPTH, 8'h55);
      arm_now();
      feed(10, 8'h11);
      i_in_valid = 1'b1;
      i_in_data  = 8'hAA;
      i_rd_en    = 1'b1;
      i_rd_addr  = 10'd10;
      cyc();
      i_in_valid = 1'b0;
      check("rf_old", 32'(o_rd_data), 32'h55);
      check("rf_count", 32'(o_count), 32'd11);
      cyc();
      i_rd_en = 1'b0;
      check("rf_new", 32'(o_rd_data), 32'hAA);

      // Randomized traffic checked by the model.
      for (int i = 0; i < 6000; i++) begin
         rst        = ($urandom_range(0, 1999) != 0);
         i_arm      = ($urandom_range(0, 1499) == 0);
         i_in_valid = ($urandom_range(0, 9) < 7);
         i_in_data  = 8'($urandom);
         i_rd_en    = ($urandom_range(0, 1) == 1);
         i_rd_addr  = ADDR_W'($urandom_range(0, 1023));
         if ((i % 1700) == 5) i_arm = 1'b1;
         cyc();
      end
      rst        = 1'b1;
      i_arm      = 1'b0;
      i_in_valid = 1'b0;
      i_rd_en    = 1'b0;
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
